// File: rtl/network_write_control.sv
// Packet write control: takes a free bufid, writes up to 128 data cycles into PCB, emits a descriptor.
// Define NETWORK_WRITE_DEBUG_EN to enable the debug packet/drop counters.
module network_write_control #(
  parameter int DATA_W = 128
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] iv_pkt_data,
  input  logic              i_pkt_data_wr,
  input  logic              i_pkt_first,
  input  logic              i_pkt_last,
  input  logic [3:0]        iv_pkt_inport,
  output logic              o_pkt_data_ready,
  input  logic [8:0]        iv_pkt_bufid,
  input  logic              i_pkt_bufid_wr,
  output logic              o_pkt_bufid_ack,
  output logic [DATA_W-1:0] ov_pkt_wdata,
  output logic [15:0]       ov_pkt_waddr,
  output logic              o_pkt_wr,
  input  logic              i_pkt_waddr_ack,
  output logic [60:0]       ov_pkt_descriptor,
  output logic              o_pkt_descriptor_wr,
  input  logic              i_pkt_descriptor_ready,
  output logic [15:0]       ov_debug_pkt_cnt,
  output logic [15:0]       ov_debug_drop_cnt,
  output logic [2:0]        pkt_write_state
);

  typedef enum logic [2:0] {
    GET_BUFID_S = 3'd0,
    WAIT_HEAD_S = 3'd1,
    WAIT_WACK_S = 3'd2,
    WAIT_BODY_S = 3'd3,
    DISCARD_S   = 3'd4,
    DESC_S      = 3'd5
  } state_t;

  state_t      state;
  logic [8:0]  bufid;
  logic [3:0]  inport;
  logic [7:0]  cyc_cnt;
  logic        err;
  logic        wrote;
  logic        last_seen;

  assign o_pkt_data_ready  = (state == WAIT_HEAD_S) || (state == WAIT_BODY_S) || (state == DISCARD_S);
  assign ov_pkt_descriptor = {39'd0, err, cyc_cnt, inport, bufid};
  assign pkt_write_state   = state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state               <= GET_BUFID_S;
      bufid               <= '0;
      inport              <= '0;
      cyc_cnt             <= '0;
      err                 <= 1'b0;
      wrote               <= 1'b0;
      last_seen           <= 1'b0;
      ov_pkt_waddr        <= '0;
      ov_pkt_wdata        <= '0;
      o_pkt_wr            <= 1'b0;
      o_pkt_bufid_ack     <= 1'b0;
      o_pkt_descriptor_wr <= 1'b0;
    end else begin
      o_pkt_bufid_ack <= 1'b0;
      case (state)
        GET_BUFID_S: begin
          if (i_pkt_bufid_wr) begin
            bufid           <= iv_pkt_bufid;
            o_pkt_bufid_ack <= 1'b1;
            state           <= WAIT_HEAD_S;
          end
        end
        WAIT_HEAD_S: begin
          // Headless cycles and heads from the invalid port are dropped; the bufid stays held.
          if (i_pkt_data_wr && i_pkt_first) begin
            if (iv_pkt_inport == 4'hf) begin
              wrote <= 1'b0;
              if (!i_pkt_last) state <= DISCARD_S;
            end else begin
              inport       <= iv_pkt_inport;
              ov_pkt_waddr <= {bufid, 7'b0};
              ov_pkt_wdata <= iv_pkt_data;
              o_pkt_wr     <= 1'b1;
              cyc_cnt      <= 8'd1;
              err          <= 1'b0;
              wrote        <= 1'b1;
              last_seen    <= i_pkt_last;
              state        <= WAIT_WACK_S;
            end
          end
        end
        WAIT_WACK_S: begin
          if (i_pkt_waddr_ack) begin
            o_pkt_wr <= 1'b0;
            if (last_seen) begin
              o_pkt_descriptor_wr <= 1'b1;
              state               <= DESC_S;
            end else begin
              state <= WAIT_BODY_S;
            end
          end
        end
        WAIT_BODY_S: begin
          if (i_pkt_data_wr) begin
            if (i_pkt_first) err <= 1'b1;
            // A full buffer never spills into the next bufid: excess cycles are discarded.
            if (cyc_cnt == 8'd128) begin
              err <= 1'b1;
              if (i_pkt_last) begin
                o_pkt_descriptor_wr <= 1'b1;
                state               <= DESC_S;
              end else begin
                state <= DISCARD_S;
              end
            end else begin
              ov_pkt_waddr <= ov_pkt_waddr + 16'd1;
              ov_pkt_wdata <= iv_pkt_data;
              o_pkt_wr     <= 1'b1;
              cyc_cnt      <= cyc_cnt + 8'd1;
              last_seen    <= i_pkt_last;
              state        <= WAIT_WACK_S;
            end
          end
        end
        DISCARD_S: begin
          if (i_pkt_data_wr && i_pkt_last) begin
            if (wrote) begin
              o_pkt_descriptor_wr <= 1'b1;
              state               <= DESC_S;
            end else begin
              state <= WAIT_HEAD_S;
            end
          end
        end
        DESC_S: begin
          if (i_pkt_descriptor_ready) begin
            o_pkt_descriptor_wr <= 1'b0;
            wrote               <= 1'b0;
            state               <= GET_BUFID_S;
          end
        end
        default: state <= GET_BUFID_S;
      endcase
    end
  end

`ifdef NETWORK_WRITE_DEBUG_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hffff) ? v : v + 16'd1;
  endfunction

  logic drop_inc;
  logic pkt_inc;
  assign drop_inc = (state == WAIT_HEAD_S) && i_pkt_data_wr && (!i_pkt_first || (iv_pkt_inport == 4'hf));
  assign pkt_inc  = (state == DESC_S) && i_pkt_descriptor_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ov_debug_pkt_cnt  <= '0;
      ov_debug_drop_cnt <= '0;
    end else begin
      if (pkt_inc)  ov_debug_pkt_cnt  <= sat_inc(ov_debug_pkt_cnt);
      if (drop_inc) ov_debug_drop_cnt <= sat_inc(ov_debug_drop_cnt);
    end
  end
`else
  assign ov_debug_pkt_cnt  = 16'd0;
  assign ov_debug_drop_cnt = 16'd0;
`endif

endmodule
